// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared spiking-network word widths and scan state encoding
package snn_pkg;

  localparam int BIT_WIDTH_MEMBRANE = 17;
  localparam int BIT_WIDTH_WEIGHT   = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EVAL = 3'd2,
    S_FIRE = 3'd3,
    S_DONE = 3'd4
  } scan_state_t;

endpackage

// File: rtl/neuron_fire_scan_if.sv
// rtl/neuron_fire_scan_if.sv - membrane memory port and spike handshake bundle
interface neuron_fire_scan_if
  import snn_pkg::*;
#(
  parameter int BIT_WIDTH_MEMBRANE = snn_pkg::BIT_WIDTH_MEMBRANE,
  parameter int ADDR_WIDTH         = 8
);

  logic                                 mem_rd_en_o;
  logic        [ADDR_WIDTH-1:0]         mem_addr_o;
  logic signed [BIT_WIDTH_MEMBRANE-1:0] mem_rd_data_i;
  logic                                 mem_wr_en_o;
  logic signed [BIT_WIDTH_MEMBRANE-1:0] mem_wr_data_o;
  logic                                 spike_valid_o;
  logic                                 spike_ready_i;
  logic        [ADDR_WIDTH-1:0]         spike_addr_o;

  // Scanner side drives the memory port and offers spikes.
  modport master (
    output mem_rd_en_o, mem_addr_o, mem_wr_en_o, mem_wr_data_o,
    output spike_valid_o, spike_addr_o,
    input  mem_rd_data_i, spike_ready_i
  );

  modport slave (
    input  mem_rd_en_o, mem_addr_o, mem_wr_en_o, mem_wr_data_o,
    input  spike_valid_o, spike_addr_o,
    output mem_rd_data_i, spike_ready_i
  );

endinterface

// File: rtl/neuron_fire_scan.sv
// rtl/neuron_fire_scan.sv - scans membrane memory, fires neurons at or above
// threshold, clears their membrane and reports each spike over a handshake.
module neuron_fire_scan
  import snn_pkg::*;
#(
  parameter int BIT_WIDTH_MEMBRANE = snn_pkg::BIT_WIDTH_MEMBRANE,
  parameter int NEURON_NUM         = 200,
  parameter int ADDR_WIDTH         = 8
)(
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 start_i,
  input  logic signed [BIT_WIDTH_MEMBRANE-1:0] threshold_i,
  neuron_fire_scan_if.master                   bus,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic        [ADDR_WIDTH:0]           spike_count_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NEURON_NUM - 1);

  scan_state_t                          state_q, state_nxt;
  logic        [ADDR_WIDTH-1:0]         n_q, n_nxt;
  logic signed [BIT_WIDTH_MEMBRANE-1:0] thr_q, thr_nxt;
  logic        [ADDR_WIDTH:0]           cnt_q, cnt_nxt;
  logic                                 fire_first_q, fire_first_nxt;
  logic                                 is_last;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      thr_q        <= '0;
      cnt_q        <= '0;
      fire_first_q <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      n_q          <= n_nxt;
      thr_q        <= thr_nxt;
      cnt_q        <= cnt_nxt;
      fire_first_q <= fire_first_nxt;
    end
  end

  assign is_last = (n_q == LAST_ADDR);

  always_comb begin
    state_nxt      = state_q;
    n_nxt          = n_q;
    thr_nxt        = thr_q;
    cnt_nxt        = cnt_q;
    fire_first_nxt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_nxt = S_READ;
          thr_nxt   = threshold_i;
          n_nxt     = '0;
          cnt_nxt   = '0;
        end
      end
      S_READ: state_nxt = S_EVAL;
      S_EVAL: begin
        // Read data arrives the cycle after the strobe, i.e. now.
        if (bus.mem_rd_data_i >= thr_q) begin
          state_nxt      = S_FIRE;
          fire_first_nxt = 1'b1;
        end else if (is_last) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_READ;
          n_nxt     = n_q + 1'b1;
        end
      end
      S_FIRE: begin
        if (bus.spike_ready_i) begin
          cnt_nxt = cnt_q + 1'b1;
          if (is_last) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_READ;
            n_nxt     = n_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        n_nxt     = '0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode from registered state so an async reset clears them at once.
  assign bus.mem_rd_en_o   = (state_q == S_READ);
  assign bus.mem_wr_en_o   = (state_q == S_FIRE) && fire_first_q;
  assign bus.mem_wr_data_o = '0;
  assign bus.mem_addr_o    = (state_q == S_READ || state_q == S_EVAL || state_q == S_FIRE)
                             ? n_q : '0;
  assign bus.spike_valid_o = (state_q == S_FIRE);
  assign bus.spike_addr_o  = (state_q == S_FIRE) ? n_q : '0;
  assign busy_o            = (state_q != S_IDLE);
  assign done_o            = (state_q == S_DONE);
  assign spike_count_o     = cnt_q;

endmodule

// File: tb/tb_neuron_fire_scan.sv
// tb/tb_neuron_fire_scan.sv - directed self-checking bench for neuron_fire_scan
module tb_neuron_fire_scan;

  localparam int BW = 17;
  localparam int AW = 8;
  localparam int NN = 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 start;
  logic signed [BW-1:0] threshold;
  logic                 busy;
  logic                 done;
  logic [AW:0]          spike_count;

  int errors = 0;
  int checks = 0;

  logic signed [BW-1:0] mem [NN];
  int wr_cnt [NN];
  int wr_bad;
  int done_cnt;
  int busy_cycles;
  int spike_q[$];
  int rd_q[$];

  neuron_fire_scan_if #(.BIT_WIDTH_MEMBRANE(BW), .ADDR_WIDTH(AW)) bus ();

  neuron_fire_scan #(
    .BIT_WIDTH_MEMBRANE(BW),
    .NEURON_NUM(NN),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .start_i(start),
    .threshold_i(threshold),
    .bus(bus),
    .busy_o(busy),
    .done_o(done),
    .spike_count_o(spike_count)
  );

  always #5 clk = ~clk;

  // Membrane memory with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd_en_o) bus.mem_rd_data_i <= mem[bus.mem_addr_o[1:0]];
    if (bus.mem_wr_en_o && bus.mem_addr_o < NN) mem[bus.mem_addr_o[1:0]] <= bus.mem_wr_data_o;
  end

  always @(negedge clk) begin
    if (bus.mem_wr_en_o) begin
      if (bus.mem_addr_o < NN) wr_cnt[bus.mem_addr_o[1:0]]++;
      if (bus.mem_addr_o >= NN || bus.mem_wr_data_o != 0) wr_bad++;
    end
    if (bus.mem_rd_en_o) rd_q.push_back(int'(bus.mem_addr_o));
    if (bus.spike_valid_o && bus.spike_ready_i) spike_q.push_back(int'(bus.spike_addr_o));
    if (done) done_cnt++;
    if (busy) busy_cycles++;
  end

  task automatic load(input int a, input int b, input int c, input int d);
    mem[0] = BW'(a);
    mem[1] = BW'(b);
    mem[2] = BW'(c);
    mem[3] = BW'(d);
  endtask

  task automatic kick(input int thr);
    @(posedge clk); #1;
    for (int i = 0; i < NN; i++) wr_cnt[i] = 0;
    wr_bad = 0; done_cnt = 0; busy_cycles = 0;
    spike_q.delete(); rd_q.delete();
    threshold = BW'(thr);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; threshold = '0; bus.spike_ready_i = 1'b1;
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_status: busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (bus.mem_rd_en_o !== 1'b0 || bus.mem_wr_en_o !== 1'b0 || bus.mem_addr_o !== '0) begin
      errors++; $display("FAIL reset_mem: rd=%b wr=%b addr=%0d expected 0 0 0",
                         bus.mem_rd_en_o, bus.mem_wr_en_o, bus.mem_addr_o);
    end
    checks++;
    if (bus.spike_valid_o !== 1'b0 || bus.spike_addr_o !== '0 || spike_count !== '0) begin
      errors++; $display("FAIL reset_spike: valid=%b addr=%0d count=%0d expected 0 0 0",
                         bus.spike_valid_o, bus.spike_addr_o, spike_count);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    bit ok;
    load(50, 100, -5, 65535);
    bus.spike_ready_i = 1'b1;
    kick(100);
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: got timeout expected done"); end
    checks++;
    if (spike_q.size() != 2 || spike_q[0] != 1 || spike_q[1] != 3) begin
      errors++; $display("FAIL basic_spikes: got n=%0d first=%0d expected n=2 addrs 1,3",
                         spike_q.size(), (spike_q.size() > 0) ? spike_q[0] : -1);
    end
    checks++;
    if (wr_cnt[0] != 0 || wr_cnt[1] != 1 || wr_cnt[2] != 0 || wr_cnt[3] != 1 || wr_bad != 0) begin
      errors++; $display("FAIL basic_writes: got %0d%0d%0d%0d bad=%0d expected 0101 bad=0",
                         wr_cnt[0], wr_cnt[1], wr_cnt[2], wr_cnt[3], wr_bad);
    end
    checks++;
    if (mem[0] !== BW'(50) || mem[1] !== '0 || mem[2] !== BW'(-5) || mem[3] !== '0) begin
      errors++; $display("FAIL basic_mem: got %0d %0d %0d %0d expected 50 0 -5 0",
                         mem[0], mem[1], mem[2], mem[3]);
    end
    checks++;
    if (busy_cycles != 11 || done_cnt != 1) begin
      errors++; $display("FAIL basic_latency: got busy=%0d done=%0d expected 11 1", busy_cycles, done_cnt);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (spike_count !== 9'd2 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_count_hold: got count=%0d busy=%b expected 2 0", spike_count, busy);
    end
  endtask

  task automatic test_sign;
    bit ok;
    load(-1, 0, -65536, 65535);
    kick(0);
    wait_done(ok);
    checks++;
    if (!ok || spike_q.size() != 2 || spike_q[0] != 1 || spike_q[1] != 3 || spike_count !== 9'd2) begin
      errors++; $display("FAIL sign_compare: got n=%0d count=%0d expected n=2 addrs 1,3 count 2",
                         spike_q.size(), spike_count);
    end
  endtask

  task automatic test_stall;
    bit ok;
    int stable;
    load(200, 0, 0, 0);
    bus.spike_ready_i = 1'b0;
    kick(100);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.spike_valid_o) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_valid: got timeout expected spike_valid"); end
    stable = (bus.spike_valid_o && bus.spike_addr_o == 0) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.spike_valid_o && bus.spike_addr_o == 0) stable++;
    end
    @(posedge clk); #1;
    bus.spike_ready_i = 1'b1;
    @(negedge clk);
    if (bus.spike_valid_o && bus.spike_addr_o == 0) stable++;
    wait_done(ok);
    checks++;
    if (stable != 6) begin errors++; $display("FAIL stall_stable: got %0d cycles expected 6", stable); end
    checks++;
    if (wr_cnt[0] != 1 || wr_cnt[1] + wr_cnt[2] + wr_cnt[3] != 0 || wr_bad != 0) begin
      errors++; $display("FAIL stall_single_write: got addr0=%0d others=%0d expected 1 0",
                         wr_cnt[0], wr_cnt[1] + wr_cnt[2] + wr_cnt[3]);
    end
    checks++;
    if (!ok || spike_q.size() != 1 || spike_q[0] != 0 || spike_count !== 9'd1) begin
      errors++; $display("FAIL stall_handshake: got n=%0d count=%0d expected 1 1", spike_q.size(), spike_count);
    end
  endtask

  task automatic test_start_ignored;
    bit ok;
    load(50, 100, -5, 65535);
    bus.spike_ready_i = 1'b1;
    kick(100);
    @(posedge clk); #1;
    threshold = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(ok);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (!ok || spike_q.size() != 2 || spike_q[0] != 1 || spike_q[1] != 3 || spike_count !== 9'd2) begin
      errors++; $display("FAIL restart_ignored: got n=%0d count=%0d expected n=2 addrs 1,3 count 2",
                         spike_q.size(), spike_count);
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL restart_single_done: got done=%0d busy=%b expected 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_fire;
    bit ok;
    load(0, 0, 200, 200);
    bus.spike_ready_i = 1'b0;
    kick(100);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.spike_valid_o && bus.spike_addr_o == 2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_fire2: got timeout expected fire at 2"); end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.spike_valid_o !== 1'b0 || bus.mem_wr_en_o !== 1'b0 ||
        bus.mem_rd_en_o !== 1'b0 || bus.mem_addr_o !== '0 || bus.spike_addr_o !== '0 || spike_count !== '0) begin
      errors++; $display("FAIL midreset_async: got busy=%b valid=%b wr=%b addr=%0d count=%0d expected all 0",
                         busy, bus.spike_valid_o, bus.mem_wr_en_o, bus.mem_addr_o, spike_count);
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt[2] != 1 || wr_cnt[3] != 0 || mem[2] !== '0 || mem[3] !== BW'(200) || done_cnt != 0) begin
      errors++; $display("FAIL midreset_writes: got w2=%0d w3=%0d m2=%0d m3=%0d done=%0d expected 1 0 0 200 0",
                         wr_cnt[2], wr_cnt[3], mem[2], mem[3], done_cnt);
    end
    bus.spike_ready_i = 1'b1;
    kick(100);
    wait_done(ok);
    checks++;
    if (!ok || rd_q.size() != 4 || rd_q[0] != 0 || spike_q.size() != 1 || spike_q[0] != 3 || spike_count !== 9'd1) begin
      errors++; $display("FAIL midreset_rescan: got reads=%0d first=%0d spikes=%0d count=%0d expected 4 0 1 1",
                         rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : -1, spike_q.size(), spike_count);
    end
  endtask

  task automatic test_all_fire;
    bit ok;
    load(-65536, -65536, -65536, -65536);
    bus.spike_ready_i = 1'b1;
    kick(-65536);
    wait_done(ok);
    checks++;
    if (!ok || spike_count !== 9'd4 || spike_q.size() != 4 || spike_q[0] != 0 || spike_q[3] != 3) begin
      errors++; $display("FAIL allfire_spikes: got count=%0d n=%0d expected 4 4", spike_count, spike_q.size());
    end
    checks++;
    if (wr_cnt[0] != 1 || wr_cnt[1] != 1 || wr_cnt[2] != 1 || wr_cnt[3] != 1 || busy_cycles != 13) begin
      errors++; $display("FAIL allfire_writes: got %0d%0d%0d%0d busy=%0d expected 1111 busy=13",
                         wr_cnt[0], wr_cnt[1], wr_cnt[2], wr_cnt[3], busy_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_stall();
    test_start_ignored();
    test_reset_mid_fire();
    test_all_fire();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
